// File: rtl/eth_sched_pkg.sv
// Shared definitions for the 10BASE-T transmit-line scheduler:
// state codes, default timing constants and counter sizing helpers.
package eth_sched_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 50000000;
  localparam int unsigned DEF_NLP_PERIOD = 800000;
  localparam int unsigned DEF_NLP_WIDTH  = 5;
  localparam int unsigned DEF_IPG        = 480;
  localparam int unsigned DEF_MAX_FRAME  = 61040;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NLP   = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_pulse_timer.sv
// Loadable down-counter: load sets the count, it then decrements to zero
// and rests there. done is high whenever the count is zero, so a load of
// N-1 yields exactly N cycles before done is seen.
module eth_pulse_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/eth_tx_sched.sv
// 10BASE-T TX line scheduler: arbitrates the line between NLP generation
// and frame transmission, inserting an inter-packet gap after each.
// Optional frame watchdog enabled by defining ETH_SCHED_WDOG_EN.
module eth_tx_sched
  import eth_sched_pkg::*;
#(
  parameter int unsigned clk_freq   = DEF_CLK_FREQ,
  parameter int unsigned NLP_PERIOD = DEF_NLP_PERIOD,
  parameter int unsigned NLP_WIDTH  = DEF_NLP_WIDTH,
  parameter int unsigned IPG        = DEF_IPG,
  parameter int unsigned MAX_FRAME  = DEF_MAX_FRAME
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_req,
  input  logic frame_done,
  output logic frame_gnt,
  output logic nlp_tx,
  output logic tx_en,
  output logic frame_abort
);

  localparam int unsigned IC_W = cnt_w(NLP_PERIOD);
  localparam logic [IC_W-1:0] IC_MAX = IC_W'(NLP_PERIOD);
`ifdef ETH_SCHED_WDOG_EN
  localparam int unsigned TMR_MAX = umax(umax(NLP_WIDTH - 1, IPG - 1), MAX_FRAME - 1);
`else
  localparam int unsigned TMR_MAX = umax(NLP_WIDTH - 1, IPG - 1);
`endif
  localparam int unsigned TMR_W = cnt_w(TMR_MAX);

  // Timing sanity: an NLP plus its gap must fit inside one NLP period,
  // otherwise the NLP spacing could not be honoured.
  if (NLP_WIDTH + IPG >= NLP_PERIOD) begin : g_bad_period
    $error("eth_tx_sched: NLP_WIDTH + IPG must be less than NLP_PERIOD");
  end
  if (NLP_WIDTH == 0 || IPG == 0 || MAX_FRAME == 0 || clk_freq == 0) begin : g_bad_zero
    $error("eth_tx_sched: timing parameters must be non-zero");
  end

  logic [1:0]      state_q, state_d;
  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            gnt_q, gnt_d;
  logic            nlp_q, nlp_d;
  logic            tx_en_q, tx_en_d;
  logic            tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic            tmr_done;
  logic            nlp_due;

  // NLP is due one cycle early so the pulse starts exactly NLP_PERIOD apart.
  assign nlp_due = (idle_cnt_q >= IC_W'(NLP_PERIOD - 1));

  // One timer serves the NLP width, the gap and (optionally) the watchdog;
  // these phases never overlap.
  eth_pulse_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef ETH_SCHED_WDOG_EN
  logic abort_q, abort_d;
`endif

  // Next-state, idle counter, timer control and registered-output decode.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = (idle_cnt_q == IC_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef ETH_SCHED_WDOG_EN
    abort_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (nlp_due) begin
          state_d    = ST_NLP;
          idle_cnt_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(NLP_WIDTH - 1);
        end else if (frame_req) begin
          state_d    = ST_FRAME;
          idle_cnt_d = '0;
`ifdef ETH_SCHED_WDOG_EN
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(MAX_FRAME - 1);
`endif
        end
      end
      ST_NLP: begin
        if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(IPG - 1);
        end
      end
      ST_FRAME: begin
        // The NLP period is measured from the end of the frame.
        idle_cnt_d = '0;
        if (frame_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(IPG - 1);
`ifdef ETH_SCHED_WDOG_EN
        end else if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(IPG - 1);
          abort_d  = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    gnt_d   = (state_d == ST_FRAME);
    nlp_d   = (state_d == ST_NLP);
    tx_en_d = gnt_d | nlp_d;
  end

  // State, idle counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      gnt_q      <= 1'b0;
      nlp_q      <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      gnt_q      <= gnt_d;
      nlp_q      <= nlp_d;
      tx_en_q    <= tx_en_d;
    end
  end

`ifdef ETH_SCHED_WDOG_EN
  // Watchdog abort pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
  assign frame_abort = abort_q;
`else
  assign frame_abort = 1'b0;
`endif

  assign frame_gnt = gnt_q;
  assign nlp_tx    = nlp_q;
  assign tx_en     = tx_en_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed scenarios with absolute
// cycle expectations plus randomized traffic against a behavioural model.
module tb_eth_tx_sched;

  localparam int NLP_P = 100;
  localparam int NLP_W = 5;
  localparam int IPG_C = 10;
  localparam int MAXF  = 200;
`ifdef ETH_SCHED_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_NLP   = 1;
  localparam int M_FRAME = 2;
  localparam int M_GAP   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_req = 1'b0;
  logic frame_done = 1'b0;
  logic frame_gnt, nlp_tx, tx_en, frame_abort;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: current phase, cycles left in timed phase, cycles since the
  // NLP period reference point, cycles spent in the current frame
  int  m_mode, m_left, m_since, m_fcyc;
  bit  m_abort;

  int  gnt_rise[$];
  int  gnt_fall[$];
  int  nlp_rise[$];
  int  nlp_cnt, abort_cnt;
  bit  prev_gnt, prev_nlp;
  int  flen;

  eth_tx_sched #(
    .clk_freq   (50000000),
    .NLP_PERIOD (NLP_P),
    .NLP_WIDTH  (NLP_W),
    .IPG        (IPG_C),
    .MAX_FRAME  (MAXF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_req   (frame_req),
    .frame_done  (frame_done),
    .frame_gnt   (frame_gnt),
    .nlp_tx      (nlp_tx),
    .tx_en       (tx_en),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_left  = 0;
    m_since = 0;
    m_fcyc  = 0;
    m_abort = 1'b0;
  endtask

  // One clock edge of the line rules, given the inputs seen at that edge.
  task automatic model_edge(input logic req, input logic done);
    m_abort = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_since >= NLP_P - 1) begin
          m_mode = M_NLP; m_left = NLP_W; m_since = 0;
        end else if (req) begin
          m_mode = M_FRAME; m_fcyc = 0; m_since = 0;
        end else begin
          m_since++;
        end
      end
      M_NLP: begin
        m_since++;
        m_left--;
        if (m_left == 0) begin m_mode = M_GAP; m_left = IPG_C; end
      end
      M_FRAME: begin
        m_fcyc++;
        if (done) begin
          m_mode = M_GAP; m_left = IPG_C; m_since = 0;
        end else if (WDOG && m_fcyc == MAXF) begin
          m_mode = M_GAP; m_left = IPG_C; m_since = 0; m_abort = 1'b1;
        end
      end
      default: begin
        m_since++;
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic observe();
    logic [3:0] exp_o;
    exp_o = {m_mode == M_FRAME, m_mode == M_NLP,
             (m_mode == M_FRAME) || (m_mode == M_NLP), m_abort};
    check_eq("outs", {frame_gnt, nlp_tx, tx_en, frame_abort}, exp_o);
    if (frame_gnt && !prev_gnt) gnt_rise.push_back(cyc);
    if (!frame_gnt && prev_gnt) gnt_fall.push_back(cyc);
    if (nlp_tx && !prev_nlp) nlp_rise.push_back(cyc);
    if (nlp_tx) nlp_cnt++;
    if (frame_abort) abort_cnt++;
    prev_gnt = frame_gnt;
    prev_nlp = nlp_tx;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(frame_req, frame_done);
    @(negedge clk);
    cyc++;
    observe();
  endtask

  // Called at a negedge (or before the first edge); ends at a negedge with
  // reset released and cycle 0 observed.
  task automatic do_reset();
    rst = 1'b1;
    frame_req = 1'b0;
    frame_done = 1'b0;
    #1;
    check_eq("rst_outs", {frame_gnt, nlp_tx, tx_en, frame_abort}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    gnt_rise.delete(); gnt_fall.delete(); nlp_rise.delete();
    nlp_cnt = 0; abort_cnt = 0; prev_gnt = 1'b0; prev_nlp = 1'b0;
    observe();
  endtask

  initial begin
    repeat (2) @(negedge clk);

    // idle link: NLPs every 100 cycles, never a grant
    do_reset();
    while (cyc < 305) tick();
    check_eq("idle_nlp0", qget(nlp_rise, 0), 100);
    check_eq("idle_nlp1", qget(nlp_rise, 1), 200);
    check_eq("idle_nlp2", qget(nlp_rise, 2), 300);
    check_eq("idle_nlp_cycles", nlp_cnt, 3 * NLP_W);
    check_eq("idle_no_gnt", gnt_rise.size(), 0);

    // frames, request held through gap, NLP/request collision, stray done
    do_reset();
    while (cyc < 390) begin
      frame_done = (cyc == 60 || cyc == 230 || cyc == 250 ||
                    cyc == 352 || cyc == 360 || cyc == 380);
      if (cyc == 20 || cyc == 200 || cyc == 231 || cyc == 350) frame_req = 1'b1;
      if (frame_gnt) frame_req = 1'b0;
      tick();
    end
    frame_done = 1'b0;
    check_eq("gnt_rise0", qget(gnt_rise, 0), 21);
    check_eq("gnt_fall0", qget(gnt_fall, 0), 61);
    check_eq("nlp_after_frame", qget(nlp_rise, 0), 161);
    check_eq("gnt_rise1", qget(gnt_rise, 1), 201);
    check_eq("gnt_fall1", qget(gnt_fall, 1), 231);
    check_eq("regrant_after_gap", qget(gnt_rise, 2), 242);
    check_eq("gnt_fall2", qget(gnt_fall, 2), 251);
    check_eq("nlp_wins_collision", qget(nlp_rise, 1), 351);
    check_eq("gnt_after_nlp_gap", qget(gnt_rise, 3), 367);
    check_eq("gnt_fall3", qget(gnt_fall, 3), 381);
    check_eq("gnt_rise_count", gnt_rise.size(), 4);

    // frame that never finishes
    do_reset();
    while (cyc < 240) begin
      if (cyc == 10) frame_req = 1'b1;
      if (frame_gnt) frame_req = 1'b0;
      tick();
    end
    check_eq("wd_gnt_rise", qget(gnt_rise, 0), 11);
`ifdef ETH_SCHED_WDOG_EN
    check_eq("wd_gnt_fall", qget(gnt_fall, 0), 211);
    check_eq("wd_abort_pulses", abort_cnt, 1);
`else
    check_eq("nowd_gnt_held", frame_gnt, 1);
    check_eq("nowd_no_abort", abort_cnt, 0);
`endif

    // asynchronous reset in the middle of a frame
    do_reset();
    while (cyc < 30) begin
      if (cyc == 5) frame_req = 1'b1;
      if (frame_gnt) frame_req = 1'b0;
      tick();
    end
    check_eq("pre_rst_gnt", frame_gnt, 1);
    do_reset();
    while (cyc < 110) tick();
    check_eq("nlp_after_rst", qget(nlp_rise, 0), 100);

    // randomized traffic against the model
    do_reset();
    flen = 0;
    repeat (20000) begin
      frame_done = 1'b0;
      if (frame_gnt) begin
        frame_req = 1'b0;
        if (flen == 0)
          flen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 250))
                                             : int'($urandom_range(1, 60));
        flen--;
        if (flen == 0) frame_done = 1'b1;
      end else begin
        flen = 0;
        if (!frame_req && $urandom_range(0, 29) == 0) frame_req = 1'b1;
        else if (frame_req && $urandom_range(0, 49) == 0) frame_req = 1'b0;
        if ($urandom_range(0, 39) == 0) frame_done = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

10BASE-T transmit-line scheduler that shares the single TX line between the frame transmitter and the normal-link-pulse (NLP) source. It emits NLPs at a fixed period while the link is idle and grants the line to frame requests. It enforces an inter-packet gap after every frame and every NLP, and suppresses NLPs while frames are on the wire. The block sits between the MAC transmit path and the line driver mux.

## Interface
Parameters:
- clk_freq, 50000000, system clock frequency in Hz (informational; timing parameters are in cycles)
- NLP_PERIOD, 800000, cycles between NLP starts while idle (16 ms at 50 MHz)
- NLP_WIDTH, 5, NLP high time in cycles (100 ns)
- IPG, 480, gap cycles after frame or NLP (9.6 us)
- MAX_FRAME, 61040, watchdog limit in cycles (1526 bytes at 10 Mb/s)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- frame_req  in  1  level request from frame transmitter; held until frame_gnt
- frame_done  in  1  one-cycle pulse, last bit of frame sent
- frame_gnt  out  1  frame transmitter owns the line
- nlp_tx  out  1  NLP pulse to line mux
- tx_en  out  1  line driver enable (NLP or FRAME)
- frame_abort  out  1  one-cycle watchdog abort pulse (0 without the macro)

## Operation
- States: IDLE, NLP, FRAME, GAP. Reset: IDLE, idle_cnt=0, gap_cnt=0, all outputs 0.
- idle_cnt: saturating, width $clog2(NLP_PERIOD+1); increments in IDLE, NLP, GAP; held at 0 in FRAME; cleared on entry to NLP and on FRAME exit.
- nlp_due = idle_cnt >= NLP_PERIOD-1.
- IDLE: if nlp_due -> NLP (wins over simultaneous frame_req); else if frame_req -> FRAME; else stay.
- NLP: nlp_tx=1, tx_en=1 for exactly NLP_WIDTH cycles -> GAP.
- FRAME: frame_gnt=1, tx_en=1; frame_done -> GAP. frame_req ignored.
- GAP: all outputs 0 for exactly IPG cycles -> IDLE. Pending frame_req or nlp_due is evaluated in the first IDLE cycle.
- frame_done outside FRAME is ignored. frame_req dropped before grant withdraws the request.
- No frames: NLP starts are exactly NLP_PERIOD cycles apart. NLP_WIDTH+IPG < NLP_PERIOD is required; elaboration-time check.

## Timing
- All outputs registered. frame_gnt rises 1 cycle after the IDLE cycle in which frame_req is sampled.
- frame_gnt and tx_en fall 1 cycle after frame_done.
- Earliest regrant after frame_done: frame_gnt high at cycle IPG+2 after the frame_done cycle.
- Reset mid-operation: outputs drop asynchronously; the NLP period restarts from 0 after release.

## Configuration
- ETH_SCHED_WDOG_EN defined: a FRAME-state counter aborts a frame that reaches MAX_FRAME cycles without frame_done. On abort, frame_gnt and tx_en drop, frame_abort pulses for 1 cycle, and the block enters GAP.
- ETH_SCHED_WDOG_EN undefined: FRAME waits indefinitely, frame_abort is tied 0, and no watchdog counter is present.

## Structure
- eth_sched_pkg: state enum, default NLP_PERIOD/NLP_WIDTH/IPG/MAX_FRAME constants, counter-width function.
- One sub-module: eth_pulse_timer, a loadable down-counter with a done flag. Used for NLP width, gap and watchdog timing.
- idle_cnt and the FSM stay in eth_tx_sched.

## Test plan
Bench parameters: NLP_PERIOD=100, NLP_WIDTH=5, IPG=10, MAX_FRAME=200.
- Idle after reset -> nlp_tx high 5 cycles starting at cycle 100, then at 200 and 300; frame_gnt stays 0.
- frame_req at cycle 20, frame_done at cycle 60 -> frame_gnt is high cycles 21–60 and low at 61; next NLP starts 100 cycles after FRAME exit.
- frame_req held during GAP -> frame_gnt is 0 for exactly 10 gap cycles and rises at IPG+2 after frame_done.
- frame_req and nlp_due in the same IDLE cycle -> NLP is sent first, then GAP, then grant; frame_done pulses outside FRAME have no effect.
- With ETH_SCHED_WDOG_EN: no frame_done -> after 200 FRAME cycles frame_abort pulses once, frame_gnt drops and GAP follows; without the macro frame_gnt stays high.
- rst asserted mid-frame -> all outputs 0 immediately; first NLP starts 100 cycles after release.
